// File: rtl/punc_debug_dump_pkg.sv
// Shared constants for the PUnC debug snapshot engine: stream tags, FSM states,
// dump sections and the END-word payload helper.
package punc_dbg_pkg;

   typedef logic [1:0] tag_t;

   localparam tag_t TAG_PC  = 2'd0;
   localparam tag_t TAG_RF  = 2'd1;
   localparam tag_t TAG_MEM = 2'd2;
   localparam tag_t TAG_END = 2'd3;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] SEND  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   // Sections share the tag encoding so the tag is captured straight from the section.
   localparam logic [1:0] SEC_PC  = TAG_PC;
   localparam logic [1:0] SEC_RF  = TAG_RF;
   localparam logic [1:0] SEC_MEM = TAG_MEM;
   localparam logic [1:0] SEC_END = TAG_END;

   function automatic logic [15:0] end_payload(input int rf_regs, input logic [15:0] mem_count);
      return 16'(1 + rf_regs) + mem_count;
   endfunction

endpackage

// File: rtl/punc_debug_dump_if.sv
// Tagged valid/ready word stream leaving the debug dump engine.
interface punc_debug_dump_if #(parameter int WORD_W = 16);
   import punc_dbg_pkg::*;

   logic              valid;
   logic              ready;
   logic [WORD_W-1:0] data;
   tag_t              tag;
   logic              last;

   modport master (output valid, data, tag, last, input ready);
   modport slave  (input valid, data, tag, last, output ready);

endinterface

// File: rtl/punc_debug_dump.sv
// Walks PC, register file and a memory window through the processor debug
// ports and streams each value as a tagged word, closed by an END count word.
module punc_debug_dump
   import punc_dbg_pkg::*;
#(
   parameter  int WORD_W  = 16,
   parameter  int RF_REGS = 8,
   localparam int RF_AW   = (RF_REGS > 1) ? $clog2(RF_REGS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       mem_base,
   input  logic [15:0]       mem_count,
   output logic              busy,
   output logic              done,
   input  logic [WORD_W-1:0] pc_debug_data,
   output logic [RF_AW-1:0]  rf_debug_addr,
   input  logic [WORD_W-1:0] rf_debug_data,
   output logic [15:0]       mem_debug_addr,
   input  logic [WORD_W-1:0] mem_debug_data,
   punc_debug_dump_if.master strm
);

   localparam logic [RF_AW-1:0] RF_LAST = RF_AW'(RF_REGS - 1);

   logic [1:0]        state;
   logic [1:0]        section;
   logic [RF_AW-1:0]  rf_idx;
   logic [15:0]       addr_ptr;
   logic [15:0]       remaining;
   logic [WORD_W-1:0] word_total;
   logic [WORD_W-1:0] src_data;

   logic              valid_q;
   logic [WORD_W-1:0] data_q;
   tag_t              tag_q;
   logic              last_q;

   assign busy           = (state == FETCH) || (state == SEND);
   assign done           = (state == DONE);
   assign rf_debug_addr  = rf_idx;
   assign mem_debug_addr = addr_ptr;

   assign strm.valid = valid_q;
   assign strm.data  = data_q;
   assign strm.tag   = tag_q;
   assign strm.last  = last_q;

   always_comb begin
      src_data = word_total;
      case (section)
         SEC_PC:  src_data = pc_debug_data;
         SEC_RF:  src_data = rf_debug_data;
         SEC_MEM: src_data = mem_debug_data;
         default: src_data = word_total;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         section    <= SEC_PC;
         rf_idx     <= '0;
         addr_ptr   <= '0;
         remaining  <= '0;
         word_total <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         tag_q      <= TAG_PC;
         last_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr_ptr   <= mem_base;
                  remaining  <= mem_count;
                  word_total <= WORD_W'(end_payload(RF_REGS, mem_count));
                  rf_idx     <= '0;
                  section    <= SEC_PC;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               data_q  <= src_data;
               tag_q   <= section;
               last_q  <= (section == SEC_END);
               valid_q <= 1'b1;
               state   <= SEND;
            end
            SEND: begin
               if (strm.ready) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  state   <= FETCH;
                  case (section)
                     SEC_PC: section <= SEC_RF;
                     SEC_RF: begin
                        if (rf_idx == RF_LAST)
                           section <= (remaining != 16'd0) ? SEC_MEM : SEC_END;
                        else
                           rf_idx <= rf_idx + RF_AW'(1);
                     end
                     SEC_MEM: begin
                        // addr_ptr wraps naturally at 16 bits
                        addr_ptr  <= addr_ptr + 16'd1;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) section <= SEC_END;
                     end
                     default: state <= DONE;
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
